// File: rtl/encoder_pkg.sv
`default_nettype none
// ============================================================================
// encoder_pkg : shared types and Gray-step decode for the encoder controller
// Rev 1.0
// ============================================================================
package encoder_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CW_PART  = 2'd1,
        CCW_PART = 2'd2,
        ERROR    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_FWD  = 2'd1,
        STEP_REV  = 2'd2,
        STEP_ILL  = 2'd3
    } step_t;

    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

    // Accumulator holds -STEPS..+STEPS with STEPS at most 4.
    localparam int ACC_W = 4;

    function automatic logic [1:0] gray_idx(input logic [1:0] g);
        logic [1:0] idx;
        case (g)
            2'b00:   idx = 2'd0;
            2'b01:   idx = 2'd1;
            2'b11:   idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    function automatic step_t gray_step(input logic [1:0] prev, input logic [1:0] cur);
        logic [1:0] d;
        step_t      s;
        d = gray_idx(cur) - gray_idx(prev);
        case (d)
            2'd0:    s = STEP_NONE;
            2'd1:    s = STEP_FWD;
            2'd2:    s = STEP_ILL;
            default: s = STEP_REV;
        endcase
        return s;
    endfunction

endpackage : encoder_pkg
`default_nettype wire

// File: rtl/evt_fifo.sv
`default_nettype none
// ============================================================================
// evt_fifo : 1-bit wide first-word-fall-through FIFO with synchronous flush
// Rev 1.0
// ============================================================================
module evt_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk10M,
    input  logic rst,
    input  logic i_flush,
    input  logic i_push,
    input  logic i_din,
    input  logic i_pop,
    output logic o_dout,
    output logic o_full,
    output logic o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

    logic [DEPTH-1:0] r_mem;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = (r_count == c_DEPTH);
    assign o_empty = (r_count == '0);
    assign o_dout  = r_mem[r_rd_ptr];

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign w_wr = i_push & (~o_full | i_pop);
    assign w_rd = i_pop & ~o_empty;

    always_ff @(posedge clk10M or negedge rst) begin
        if (!rst) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : evt_fifo
`default_nettype wire

// File: rtl/encoder_ctrl.sv
`default_nettype none
// ============================================================================
// encoder_ctrl : quadrature sequencing, bounded position and detent event queue
// Rev 1.0
// ============================================================================
module encoder_ctrl
    import encoder_pkg::*;
#(
    parameter int POS_W      = 8,
    parameter int POS_MAX    = 100,
    parameter int STEPS      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk10M,
    input  logic             rst,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             wrap_en,
    input  logic             clr,
    input  logic             evt_ready,
    output logic             evt_valid,
    output logic             evt_dir,
    output logic [POS_W-1:0] pos,
    output logic             err,
    output logic             ovf
);

    localparam logic [POS_W-1:0]        c_POS_MAX = POS_W'(POS_MAX);
    localparam logic signed [ACC_W-1:0] c_ACC_CW  = ACC_W'(STEPS - 1);
    localparam logic signed [ACC_W-1:0] c_ACC_CCW = ACC_W'(1 - STEPS);
    localparam logic signed [ACC_W-1:0] c_ACC_ONE = ACC_W'(1);

    logic [1:0]              r_cur;
    logic [1:0]              r_prev;
    logic                    r_cur_vld;
    logic                    r_primed;
    state_t                  r_state;
    logic signed [ACC_W-1:0] r_acc;
    logic [POS_W-1:0]        r_pos;
    logic                    r_err;
    logic                    r_ovf;

    step_t                   w_step;
    logic                    w_cw_det;
    logic                    w_ccw_det;
    logic signed [ACC_W-1:0] w_acc_inc;
    logic signed [ACC_W-1:0] w_acc_dec;
    logic [POS_W-1:0]        w_pos_nxt;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_head;

    function automatic state_t state_of(input logic signed [ACC_W-1:0] a);
        state_t s;
        if (a == '0)
            s = IDLE;
        else if (a[ACC_W-1])
            s = CCW_PART;
        else
            s = CW_PART;
        return s;
    endfunction

    // prev only becomes meaningful one sample after cur was first loaded.
    always_ff @(posedge clk10M or negedge rst) begin
        if (!rst) begin
            r_cur     <= 2'b00;
            r_prev    <= 2'b00;
            r_cur_vld <= 1'b0;
            r_primed  <= 1'b0;
        end else begin
            r_cur  <= {a_in, b_in};
            r_prev <= r_cur;
            if (clr) begin
                r_cur_vld <= 1'b0;
                r_primed  <= 1'b0;
            end else begin
                r_cur_vld <= 1'b1;
                r_primed  <= r_cur_vld;
            end
        end
    end

    always_comb begin
        w_step    = r_primed ? gray_step(r_prev, r_cur) : STEP_NONE;
        w_acc_inc = r_acc + c_ACC_ONE;
        w_acc_dec = r_acc - c_ACC_ONE;
        w_cw_det  = (r_state != ERROR) && (w_step == STEP_FWD) && (r_acc == c_ACC_CW);
        w_ccw_det = (r_state != ERROR) && (w_step == STEP_REV) && (r_acc == c_ACC_CCW);
    end

    always_ff @(posedge clk10M or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_err   <= 1'b0;
        end else if (clr) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ERROR: begin
                    if (w_step == STEP_ILL)
                        r_err <= 1'b1;
                    else if (r_cur == 2'b00 || r_cur == 2'b11)
                        r_state <= IDLE;
                end
                default: begin
                    case (w_step)
                        STEP_ILL: begin
                            r_state <= ERROR;
                            r_acc   <= '0;
                            r_err   <= 1'b1;
                        end
                        STEP_FWD: begin
                            if (w_cw_det) begin
                                r_acc   <= '0;
                                r_state <= IDLE;
                            end else begin
                                r_acc   <= w_acc_inc;
                                r_state <= state_of(w_acc_inc);
                            end
                        end
                        STEP_REV: begin
                            if (w_ccw_det) begin
                                r_acc   <= '0;
                                r_state <= IDLE;
                            end else begin
                                r_acc   <= w_acc_dec;
                                r_state <= state_of(w_acc_dec);
                            end
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end

    // A saturated detent leaves pos unchanged and therefore raises no event.
    always_comb begin
        w_pos_nxt = r_pos;
        if (w_cw_det)
            w_pos_nxt = (r_pos == c_POS_MAX) ? (wrap_en ? '0 : c_POS_MAX) : r_pos + 1'b1;
        else if (w_ccw_det)
            w_pos_nxt = (r_pos == '0) ? (wrap_en ? c_POS_MAX : '0) : r_pos - 1'b1;
        w_push = (w_pos_nxt != r_pos);
    end

    assign w_pop = ~w_empty & evt_ready;

    always_ff @(posedge clk10M or negedge rst) begin
        if (!rst) begin
            r_pos <= '0;
            r_ovf <= 1'b0;
        end else if (clr) begin
            r_pos <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_pos <= w_pos_nxt;
            if (w_push && w_full && !w_pop)
                r_ovf <= 1'b1;
        end
    end

    evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk10M  (clk10M),
        .rst     (rst),
        .i_flush (clr),
        .i_push  (w_push & ~clr),
        .i_din   (w_cw_det ? DIR_CW : DIR_CCW),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign evt_valid = ~w_empty;
    assign evt_dir   = w_head;
    assign pos       = r_pos;
    assign err       = r_err;
    assign ovf       = r_ovf;

endmodule : encoder_ctrl
`default_nettype wire

// File: tb/tb_encoder_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_encoder_ctrl : scoreboard bench with a detent-level reference model
// Rev 1.0
// ============================================================================
module tb_encoder_ctrl;

    localparam int POS_W   = 8;
    localparam int POS_MAX = 100;
    localparam int STEPS   = 4;
    localparam int DEPTH   = 4;

    logic             clk10M = 1'b0;
    logic             rst = 1'b0;
    logic             a_in = 1'b1;
    logic             b_in = 1'b1;
    logic             wrap_en = 1'b0;
    logic             clr = 1'b0;
    logic             evt_ready = 1'b0;
    logic             evt_valid;
    logic             evt_dir;
    logic [POS_W-1:0] pos;
    logic             err;
    logic             ovf;

    encoder_ctrl #(
        .POS_W      (POS_W),
        .POS_MAX    (POS_MAX),
        .STEPS      (STEPS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk10M    (clk10M),
        .rst       (rst),
        .a_in      (a_in),
        .b_in      (b_in),
        .wrap_en   (wrap_en),
        .clr       (clr),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .evt_dir   (evt_dir),
        .pos       (pos),
        .err       (err),
        .ovf       (ovf)
    );

    always #50 clk10M = ~clk10M;

    int n_checks = 0;
    int n_errors = 0;
    int n_pops   = 0;
    bit exp_q[$];

    // Reference model state: detent-level view of the encoder.
    int m_pos = 0;
    int m_acc = 0;
    bit m_err = 1'b0;
    bit m_ovf = 1'b0;
    bit m_errst = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int gidx(input bit [1:0] lv);
        bit [1:0] seq [4];
        seq = '{2'b00, 2'b01, 2'b11, 2'b10};
        for (int i = 0; i < 4; i++)
            if (seq[i] == lv) return i;
        return 0;
    endfunction

    function automatic bit [1:0] gval(input int i);
        bit [1:0] seq [4];
        seq = '{2'b00, 2'b01, 2'b11, 2'b10};
        return seq[i % 4];
    endfunction

    function automatic bit [1:0] fwd(input bit [1:0] lv);
        return gval(gidx(lv) + 1);
    endfunction

    function automatic bit [1:0] rev(input bit [1:0] lv);
        return gval(gidx(lv) + 3);
    endfunction

    task automatic model_clear();
        m_pos = 0; m_acc = 0; m_err = 0; m_ovf = 0; m_errst = 0;
        exp_q.delete();
    endtask

    task automatic model_detent(input bit dir);
        int np;
        if (dir) np = (m_pos == POS_MAX) ? (wrap_en ? 0 : POS_MAX) : m_pos + 1;
        else     np = (m_pos == 0) ? (wrap_en ? POS_MAX : 0) : m_pos - 1;
        if (np != m_pos) begin
            m_pos = np;
            if (exp_q.size() == DEPTH) m_ovf = 1'b1;
            else exp_q.push_back(dir);
        end
    endtask

    task automatic model_change(input bit [1:0] olv, input bit [1:0] nlv);
        int d;
        bit rest;
        d = (gidx(nlv) - gidx(olv) + 4) % 4;
        rest = (nlv == 2'b00) || (nlv == 2'b11);
        if (d == 0) return;
        if (d == 2) begin
            m_err = 1'b1; m_acc = 0; m_errst = !rest;
            return;
        end
        if (m_errst) begin
            if (rest) m_errst = 1'b0;
            return;
        end
        m_acc += (d == 1) ? 1 : -1;
        if (m_acc == STEPS) begin
            m_acc = 0; model_detent(1'b1);
        end else if (m_acc == -STEPS) begin
            m_acc = 0; model_detent(1'b0);
        end
    endtask

    task automatic chk_state();
        chk("pos", 32'(pos), 32'(m_pos));
        chk("err", 32'(err), 32'(m_err));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("evt_valid", 32'(evt_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) chk("evt_dir_head", 32'(evt_dir), 32'(exp_q[0]));
    endtask

    // Called 1ns after a rising edge; each level is held for two edges.
    task automatic do_step(input bit [1:0] nlv, input bit nrdy, input int rdy_after, input bit clr_after);
        bit [1:0] olv;
        olv = {a_in, b_in};
        {a_in, b_in} = nlv;
        evt_ready = nrdy;
        @(posedge clk10M); #1;
        if (rdy_after >= 0) evt_ready = rdy_after[0];
        if (clr_after) clr = 1'b1;
        @(posedge clk10M); #1;
        if (clr_after) begin
            clr = 1'b0;
            model_clear();
            repeat (3) @(posedge clk10M);
            #1;
        end else begin
            model_change(olv, nlv);
        end
        chk_state();
    endtask

    task automatic step(input bit [1:0] nlv);
        do_step(nlv, evt_ready, -1, 1'b0);
    endtask

    task automatic cw_detent();
        repeat (STEPS) step(fwd({a_in, b_in}));
    endtask

    task automatic ccw_detent();
        repeat (STEPS) step(rev({a_in, b_in}));
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk10M); #1;
        clr = 1'b0;
        model_clear();
        repeat (3) @(posedge clk10M);
        #1;
        chk_state();
    endtask

    // Monitor: every handshake retires the oldest expected event.
    initial begin
        forever begin
            @(negedge clk10M);
            if (rst && evt_valid && evt_ready) begin
                n_pops++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_pop: got dir %0d expected no event at %0t", evt_dir, $time);
                end else begin
                    chk("evt_dir", 32'(evt_dir), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n0;
        int  r;
        bit  bias;
        bit [1:0] cl;
        bit [1:0] nl;

        repeat (3) @(posedge clk10M);
        #1;
        chk("rst_pos", 32'(pos), 32'd0);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_dir", 32'(evt_dir), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk10M);
        rst = 1'b1;
        repeat (3) @(posedge clk10M);
        #1;

        // One forward detent, consumer always ready.
        evt_ready = 1'b1;
        n0 = n_pops;
        cw_detent();
        chk("t1_pos", 32'(pos), 32'd1);
        chk("t1_valid_rise", 32'(evt_valid), 32'd1);
        @(posedge clk10M); #1;
        chk("t1_valid_fall", 32'(evt_valid), 32'd0);
        chk("t1_pops", 32'(n_pops - n0), 32'd1);

        // Bounds: wrap down from 0, saturate at max, wrap up from max.
        do_clr();
        wrap_en = 1'b1;
        ccw_detent();
        chk("t2_wrap_ccw", 32'(pos), 32'(POS_MAX));
        @(posedge clk10M); #1;
        wrap_en = 1'b0;
        n0 = n_pops;
        cw_detent();
        @(posedge clk10M); #1;
        chk("t2_sat_pos", 32'(pos), 32'(POS_MAX));
        chk("t2_sat_noevt", 32'(n_pops - n0), 32'd0);
        wrap_en = 1'b1;
        cw_detent();
        chk("t2_wrap_cw", 32'(pos), 32'd0);
        @(posedge clk10M); #1;

        // Mid-detent reversal cancels out.
        step(fwd({a_in, b_in}));
        step(fwd({a_in, b_in}));
        step(rev({a_in, b_in}));
        step(rev({a_in, b_in}));
        chk("t3_idle", 32'(dut.r_state == encoder_pkg::IDLE), 32'd1);
        chk("t3_pos", 32'(pos), 32'd0);
        cw_detent();

        // Illegal transitions and recovery.
        step({a_in, b_in} ^ 2'b11);
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_fsm_err", 32'(dut.r_state == encoder_pkg::ERROR), 32'd1);
        step(fwd({a_in, b_in}));
        step({a_in, b_in} ^ 2'b11);
        step(fwd({a_in, b_in}));
        n0 = m_pos;
        cw_detent();
        chk("t4_detent_after_err", 32'(pos), 32'(n0 + 1));
        chk("t4_err_sticky", 32'(err), 32'd1);
        do_clr();
        chk("t4_err_clr", 32'(err), 32'd0);

        // Overflow with a stalled consumer, then drain.
        evt_ready = 1'b0;
        repeat (6) cw_detent();
        chk("t5_pos", 32'(pos), 32'd6);
        chk("t5_ovf", 32'(ovf), 32'd1);
        n0 = n_pops;
        evt_ready = 1'b1;
        repeat (8) @(posedge clk10M);
        #1;
        chk("t5_pops", 32'(n_pops - n0), 32'd4);
        chk("t5_empty", 32'(evt_valid), 32'd0);

        // Full FIFO: detent coinciding with a pop is not dropped.
        do_clr();
        evt_ready = 1'b0;
        repeat (4) cw_detent();
        repeat (STEPS - 1) step(fwd({a_in, b_in}));
        do_step(fwd({a_in, b_in}), 1'b0, 1, 1'b0);
        chk("t6_nodrop_ovf", 32'(ovf), 32'd0);
        chk("t6_pos", 32'(pos), 32'd5);

        // clr on the same edge as a detent wins.
        evt_ready = 1'b0;
        repeat (5) cw_detent();
        step({a_in, b_in} ^ 2'b11);
        repeat (STEPS - 1) step(fwd({a_in, b_in}));
        do_step(fwd({a_in, b_in}), 1'b0, -1, 1'b1);
        chk("t6_clr_pos", 32'(pos), 32'd0);
        chk("t6_clr_valid", 32'(evt_valid), 32'd0);
        chk("t6_clr_err", 32'(err), 32'd0);
        chk("t6_clr_ovf", 32'(ovf), 32'd0);

        // Randomized walk against the model.
        bias = 1'b1;
        for (int k = 0; k < 400; k++) begin
            r  = int'($urandom_range(0, 99));
            cl = {a_in, b_in};
            if ($urandom_range(0, 19) == 0) bias = ~bias;
            if ($urandom_range(0, 9) == 0) wrap_en = 1'($urandom_range(0, 1));
            if (r < 3)       nl = cl ^ 2'b11;
            else if (r < 8)  nl = cl;
            else if (r < 78) nl = bias ? fwd(cl) : rev(cl);
            else             nl = bias ? rev(cl) : fwd(cl);
            do_step(nl, $urandom_range(0, 9) < 6, -1, $urandom_range(0, 99) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_encoder_ctrl
`default_nettype wire

// File: doc/encoder_ctrl.md
Name: encoder_ctrl

Overview:
- Controller for the debounced quadrature encoder path. Consumes debounced A/B levels and runs the quadrature sequencing FSM.
- Converts full detents into a bounded position register and queues per-detent direction events for a slow consumer over a valid/ready handshake.
- Sits between the debounce stage and downstream logic, replacing ad-hoc pulse/direction registers with one sequenced, checkable block.

Parameters:
- POS_W, 8, width of position register.
- POS_MAX, 100, upper position bound (lower bound 0); must be < 2**POS_W.
- STEPS, 4, quadrature sub-steps per detent (2 or 4).
- FIFO_DEPTH, 4, event buffer entries (power of 2).

Ports:
- clk10M  in  1  system clock, 10 MHz.
- rst  in  1  asynchronous, active-low reset.
- a_in  in  1  debounced channel A, synchronous to clk10M.
- b_in  in  1  debounced channel B, synchronous to clk10M.
- wrap_en  in  1  1 = wrap at bounds; 0 = saturate.
- clr  in  1  synchronous clear of position, FSM, FIFO and flags.
- evt_ready  in  1  consumer accepts head event.
- evt_valid  out  1  FIFO non-empty.
- evt_dir  out  1  head event direction: 1 = CW, 0 = CCW.
- pos  out  POS_W  current position, 0..POS_MAX.
- err  out  1  sticky illegal-transition flag.
- ovf  out  1  sticky event-drop flag.

Behaviour:
- Reset (rst=0, async): pos=0, evt_valid=0, evt_dir=0, err=0, ovf=0, FIFO empty, FSM=IDLE, acc=0, primed=0.
- Sampling: {a_in,b_in} registered into cur every cycle. The first sample after reset or clr loads prev only (primed<=1); no transition is decoded.
- Decode cur vs prev, Gray order 00->01->11->10->00:
  - Forward step = +1 sub-step.
  - Reverse step = -1 sub-step.
  - Equal = no-op.
  - Two-bit change = illegal.
  - prev<=cur every cycle.
- FSM states: IDLE (acc=0), CW_PART (acc>0), CCW_PART (acc<0), ERROR.
  - Sub-steps move acc by ±1. A reversal mid-detent simply counts back. acc=0 returns the FSM to IDLE.
  - acc reaching +STEPS gives a CW detent; acc reaching -STEPS gives a CCW detent. On either detent acc<=0 and the FSM returns to IDLE.
  - Illegal transition in any state: FSM=ERROR, acc=0, err<=1. No position change, no event.
  - In ERROR, all steps are ignored. The FSM returns to IDLE on the first cycle cur==2'b00 or cur==2'b11.
- Position update on a detent:
  - CW: pos==POS_MAX gives wrap_en ? 0 : POS_MAX; otherwise pos+1.
  - CCW: pos==0 gives wrap_en ? POS_MAX : 0; otherwise pos-1.
  - An event is pushed only if pos actually changes; saturated detents produce no event.
- Latency: an input change sampled at edge N updates pos and pushes the event at edge N+1. evt_valid rises after edge N+1 if the FIFO was empty.
- FIFO:
  - Pop on evt_valid & evt_ready. evt_dir shows the head entry, FWFT.
  - Simultaneous push and pop are legal at any level, including full.
  - Push when full without pop: event dropped, ovf<=1, pos still updates.
  - Pop when empty: ignored.
- clr (sync, highest priority below reset): pos=0, acc=0, FSM=IDLE, FIFO flushed, err=0, ovf=0, primed=0. A detent completing in the same cycle is discarded.
- wrap_en may change any cycle; it takes effect on the next detent.

Decomposition:
- encoder_pkg holds:
  - state enum (IDLE, CW_PART, CCW_PART, ERROR);
  - Gray-step decode function returning +1/-1/0/illegal;
  - direction constants DIR_CW=1, DIR_CCW=0.
- Sub-module evt_fifo: 1-bit-wide, FIFO_DEPTH-deep synchronous FWFT FIFO. It has push, pop, full, empty and flush, and shares clk10M and rst.

Test Plan:
- Reset then 4 forward Gray steps from 11 (11->10->00->01->11), evt_ready=1 -> pos=1; one event evt_dir=1; evt_valid high exactly 1 cycle; err=0.
- pos at 100, wrap_en=0, one CW detent -> pos stays 100, no event. Same with wrap_en=1 -> pos=0, event evt_dir=1. From pos=0, one CCW detent with wrap_en=1 -> pos=100, evt_dir=0.
- Two forward sub-steps then two reverse sub-steps -> acc back to 0, FSM=IDLE, pos unchanged, no event.
- Jump 00->11 -> err=1, FSM=ERROR. Further steps are ignored until cur=00/11. The next full detent counts normally, and err stays 1 until a clr pulse.
- evt_ready=0, 6 CW detents from pos=0 -> pos=6; FIFO holds 4 entries; ovf=1. Then evt_ready=1 -> exactly 4 pops, all evt_dir=1.
- FIFO full: detent coinciding with a pop -> no drop, ovf unchanged. clr asserted in the same cycle as a detent -> pos=0, evt_valid=0, err=ovf=0.
